// File: rtl/emoji_pkg.sv
// Shared definitions for the emoji display path: index width, default image
// count, scheduler states, background colour and an index wrap helper.
package emoji_pkg;

  localparam int          NUM_EMOJI_DEF = 8;
  localparam int          EMOJI_IDX_W   = 3;
  localparam logic [15:0] BG_COLOUR     = 16'h001F;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VB = 2'd1,
    ST_HOLD    = 2'd2
  } emoji_state_e;

  // Next image index, wrapping to 0 past the last valid image.
  function automatic logic [EMOJI_IDX_W-1:0] emoji_wrap_inc(
    input logic [EMOJI_IDX_W-1:0] idx,
    input logic [EMOJI_IDX_W:0]   num
  );
    logic [EMOJI_IDX_W:0] inc_s;
    inc_s = {1'b0, idx} + {{EMOJI_IDX_W{1'b0}}, 1'b1};
    if (inc_s >= num) begin
      return {EMOJI_IDX_W{1'b0}};
    end else begin
      return inc_s[EMOJI_IDX_W-1:0];
    end
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. Bit 0 is the button side, bit 1 the UART side.
// The grant is combinational; the internal pointer remembers who was served
// last so that a tie goes to the other side. After reset the button wins.
module rr_arbiter2 (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  logic uart_prio_r;

  // Resolve a tie with the pointer, otherwise pass the single requester.
  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      if (uart_prio_r) begin
        grant = 2'b10;
      end else begin
        grant = 2'b01;
      end
    end else begin
      grant = req;
    end
  end

  // Give priority to whichever side was not served by this grant.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      uart_prio_r <= 1'b0;
    end else if (en && (req != 2'b00)) begin
      uart_prio_r <= grant[0];
    end else begin
      uart_prio_r <= uart_prio_r;
    end
  end

endmodule

// File: rtl/emoji_swap_scheduler.sv
// Emoji swap scheduler: arbitrates button/UART image requests, lands the new
// image index only on a frame_tick (vertical blanking) and then holds it for
// HOLD_FRAMES frames. Optional feature macro: EMOJI_AUTO_CYCLE_EN adds an
// idle-frame counter that advances the image after AUTO_FRAMES quiet frames.
module emoji_swap_scheduler
  import emoji_pkg::*;
#(
  parameter int NUM_EMOJI   = NUM_EMOJI_DEF,
  parameter int HOLD_FRAMES = 60,
  parameter int AUTO_FRAMES = 300
) (
  input  logic                   vga_clk,
  input  logic                   sys_rst_n,
  input  logic                   frame_tick,
  input  logic                   btn_req,
  input  logic [EMOJI_IDX_W-1:0] btn_idx,
  input  logic                   uart_req,
  input  logic [EMOJI_IDX_W-1:0] uart_idx,
  output logic                   btn_ack,
  output logic                   uart_ack,
  output logic [EMOJI_IDX_W-1:0] emoji_sel,
  output logic                   swap_pulse,
  output logic                   busy
);

  localparam int                   NUM_W  = EMOJI_IDX_W + 1;
  localparam logic [NUM_W-1:0]     NUM_L  = NUM_W'(NUM_EMOJI);
  localparam int                   HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam logic [HOLD_W-1:0]    HOLD_L = HOLD_W'(HOLD_FRAMES);

  emoji_state_e           state_r, state_nxt_s;
  logic [EMOJI_IDX_W-1:0] pending_r, pending_nxt_s;
  logic [EMOJI_IDX_W-1:0] sel_r, sel_nxt_s;
  logic [HOLD_W-1:0]      hold_r, hold_nxt_s;
  logic                   btn_ack_r, btn_ack_nxt_s;
  logic                   uart_ack_r, uart_ack_nxt_s;
  logic                   swap_r, swap_nxt_s;
  logic                   busy_r;
  // High during the ack cycle: the requester still holds req and any
  // frame_tick in this cycle must not land the swap.
  logic                   gap_r, gap_nxt_s;
  logic [1:0]             ext_req_s;
  logic [1:0]             grant_s;
  logic                   arb_en_s;
  logic [EMOJI_IDX_W-1:0] grant_idx_s;
  logic                   idx_ok_s;

`ifdef EMOJI_AUTO_CYCLE_EN
  localparam int                IDLE_W = (AUTO_FRAMES > 0) ? $clog2(AUTO_FRAMES + 1) : 1;
  localparam logic [IDLE_W-1:0] AUTO_L = IDLE_W'(AUTO_FRAMES);
  logic [IDLE_W-1:0] idle_r, idle_nxt_s;
`endif

  assign ext_req_s   = {uart_req, btn_req};
  assign grant_idx_s = grant_s[1] ? uart_idx : btn_idx;
  assign idx_ok_s    = ({1'b0, grant_idx_s} < NUM_L) && (grant_idx_s != sel_r);

  rr_arbiter2 u_arb (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .req       (ext_req_s),
    .en        (arb_en_s),
    .grant     (grant_s)
  );

  // Next-state and next-output decode for the scheduler FSM.
  always_comb begin
    state_nxt_s    = state_r;
    pending_nxt_s  = pending_r;
    sel_nxt_s      = sel_r;
    hold_nxt_s     = hold_r;
    btn_ack_nxt_s  = 1'b0;
    uart_ack_nxt_s = 1'b0;
    swap_nxt_s     = 1'b0;
    gap_nxt_s      = 1'b0;
    arb_en_s       = 1'b0;
`ifdef EMOJI_AUTO_CYCLE_EN
    idle_nxt_s     = idle_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (gap_r) begin
          state_nxt_s = ST_IDLE;
        end else if (ext_req_s != 2'b00) begin
          arb_en_s       = 1'b1;
          btn_ack_nxt_s  = grant_s[0];
          uart_ack_nxt_s = grant_s[1];
          gap_nxt_s      = 1'b1;
`ifdef EMOJI_AUTO_CYCLE_EN
          idle_nxt_s     = {IDLE_W{1'b0}};
`endif
          if (idx_ok_s) begin
            pending_nxt_s = grant_idx_s;
            state_nxt_s   = ST_WAIT_VB;
          end else begin
            state_nxt_s   = ST_IDLE;
          end
        end
`ifdef EMOJI_AUTO_CYCLE_EN
        else if (idle_r == AUTO_L) begin
          idle_nxt_s    = {IDLE_W{1'b0}};
          pending_nxt_s = emoji_wrap_inc(sel_r, NUM_L);
          state_nxt_s   = ST_WAIT_VB;
        end else if (frame_tick) begin
          idle_nxt_s    = idle_r + IDLE_W'(1'b1);
        end
`endif
        else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT_VB: begin
        if (frame_tick && !gap_r) begin
          sel_nxt_s   = pending_r;
          swap_nxt_s  = 1'b1;
          hold_nxt_s  = HOLD_L;
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_WAIT_VB;
        end
      end
      ST_HOLD: begin
        if (hold_r == {HOLD_W{1'b0}}) begin
          state_nxt_s = ST_IDLE;
        end else if (frame_tick) begin
          hold_nxt_s  = hold_r - HOLD_W'(1'b1);
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Register state, counters and every output; reset drops any pending swap.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r    <= ST_IDLE;
      pending_r  <= {EMOJI_IDX_W{1'b0}};
      sel_r      <= {EMOJI_IDX_W{1'b0}};
      hold_r     <= {HOLD_W{1'b0}};
      btn_ack_r  <= 1'b0;
      uart_ack_r <= 1'b0;
      swap_r     <= 1'b0;
      busy_r     <= 1'b0;
      gap_r      <= 1'b0;
`ifdef EMOJI_AUTO_CYCLE_EN
      idle_r     <= {IDLE_W{1'b0}};
`endif
    end else begin
      state_r    <= state_nxt_s;
      pending_r  <= pending_nxt_s;
      sel_r      <= sel_nxt_s;
      hold_r     <= hold_nxt_s;
      btn_ack_r  <= btn_ack_nxt_s;
      uart_ack_r <= uart_ack_nxt_s;
      swap_r     <= swap_nxt_s;
      busy_r     <= (state_nxt_s != ST_IDLE);
      gap_r      <= gap_nxt_s;
`ifdef EMOJI_AUTO_CYCLE_EN
      idle_r     <= idle_nxt_s;
`endif
    end
  end

  assign btn_ack    = btn_ack_r;
  assign uart_ack   = uart_ack_r;
  assign emoji_sel  = sel_r;
  assign swap_pulse = swap_r;
  assign busy       = busy_r;

endmodule

// File: doc/emoji_swap_scheduler.md
EMOJI_SWAP_SCHEDULER -- requirements
Module: emoji_swap_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_EMOJI, default 8: number of selectable emoji images (idx range 0..NUM_EMOJI-1).
REQ-002 The block SHALL have parameter HOLD_FRAMES, default 60: minimum frames an emoji stays selected after a swap.
REQ-003 The block SHALL have parameter AUTO_FRAMES, default 300: idle frames before auto-advance (macro-dependent).
REQ-004 The block SHALL have port vga_clk, input, 1: pixel clock.
REQ-005 The block SHALL have port sys_rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 The block SHALL have port frame_tick, input, 1: one-cycle pulse at start of vertical blanking.
REQ-007 The block SHALL have ports btn_req (input, 1) and btn_idx (input, 3): button requester; req level-held with idx stable until ack.
REQ-008 The block SHALL have ports uart_req (input, 1) and uart_idx (input, 3): UART requester; same rules.
REQ-009 The block SHALL have ports btn_ack and uart_ack, output, 1: one-cycle grant acknowledge.
REQ-010 The block SHALL have port emoji_sel, output, 3: image index driven to the display datapath.
REQ-011 The block SHALL have port swap_pulse, output, 1: one-cycle pulse in the cycle emoji_sel changes.
REQ-012 The block SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-013 FSM states SHALL be IDLE, WAIT_VB and HOLD.
REQ-014 IDLE: when any req is high, the block SHALL grant one requester, pulse its ack in the next cycle, latch its idx into pending_idx and enter WAIT_VB.
REQ-015 Simultaneous btn_req and uart_req SHALL be resolved round-robin: the requester not granted last wins; after reset, btn wins first.
REQ-016 A granted idx >= NUM_EMOJI SHALL still be acked but discarded, with the FSM staying in IDLE.
REQ-017 A granted idx equal to the current emoji_sel SHALL be acked and discarded with no swap_pulse.
REQ-018 WAIT_VB: on frame_tick, emoji_sel SHALL load pending_idx in the same edge, swap_pulse SHALL be high for that one cycle, the hold counter SHALL load HOLD_FRAMES, and the FSM SHALL enter HOLD.
REQ-019 HOLD: the hold counter SHALL decrement by one on each frame_tick; when it is 0, the FSM SHALL return to IDLE on the next cycle. HOLD_FRAMES=0 SHALL mean exactly one cycle in HOLD.
REQ-020 In WAIT_VB and HOLD, requests SHALL NOT be acked; requesters stall and are served in IDLE.
REQ-021 emoji_sel SHALL change only on a frame_tick edge, so it never tears mid-frame.
REQ-022 Latency SHALL be 1 cycle from req to ack in IDLE; the swap lands on the first frame_tick after ack, excluding a frame_tick coincident with the ack cycle.
REQ-023 Counters SHALL be sized $clog2(max+1) and SHALL never wrap.

Reset
REQ-024 While sys_rst_n is low (asynchronous assert), the block SHALL hold state IDLE, emoji_sel=0, swap_pulse=0, acks=0, busy=0, counters=0, and round-robin pointer=btn.
REQ-025 Reset asserted mid-WAIT_VB or mid-HOLD SHALL drop pending_idx without a swap.

Configuration
REQ-026 With EMOJI_AUTO_CYCLE_EN defined: an idle-frame counter SHALL count frame_ticks while in IDLE with no req; on reaching AUTO_FRAMES, the block SHALL internally request (emoji_sel+1) mod NUM_EMOJI with no ack output, follow the WAIT_VB/HOLD path, and clear the counter. Any external grant SHALL clear the counter.
REQ-027 Without EMOJI_AUTO_CYCLE_EN, no idle counter SHALL exist and emoji_sel SHALL change only via external requests.

Structure
REQ-028 Shared package emoji_pkg SHALL hold NUM_EMOJI default, EMOJI_IDX_W=3, the state enum, and the 0x001F background colour constant.
REQ-029 Sub-module rr_arbiter2 (2-way round-robin, grant plus last-grant pointer) SHALL be instantiated once.

Verification
REQ-030 Bench SHALL cover: btn_req idx=3 in IDLE -> btn_ack at +1 cycle; emoji_sel=3 with swap_pulse on the next frame_tick; busy for HOLD_FRAMES=60 ticks.
REQ-031 Bench SHALL cover: btn and uart both requesting (idx 2 and 5) from reset -> btn granted first; uart acked after HOLD expires; emoji_sel 2 then 5.
REQ-032 Bench SHALL cover: uart_idx=7 with NUM_EMOJI=6 -> ack, no swap, busy stays 0.
REQ-033 Bench SHALL cover: request idx equal to current emoji_sel -> ack, no swap_pulse.
REQ-034 Bench SHALL cover: reset pulse while in WAIT_VB -> emoji_sel=0, no swap on the following frame_tick.
REQ-035 Bench SHALL cover, with EMOJI_AUTO_CYCLE_EN and AUTO_FRAMES=4: no requests -> emoji_sel 0 to 1 on the 5th frame_tick after entering IDLE.
